// File: rtl/multi_cycle_measurer_if.sv
// Bundles the per-channel START inputs, the statistics clear and all
// measurement outputs of multi_cycle_measurer into one port.
interface multi_cycle_measurer_if #(
    parameter int N_CH  = 4,
    parameter int OUT_W = 8
);
    logic [N_CH-1:0]       in_start;
    logic                  clr_stats;
    logic [N_CH*OUT_W-1:0] out_length;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_sat;
    logic [N_CH*OUT_W-1:0] out_min;
    logic [N_CH*OUT_W-1:0] out_max;
    logic [N_CH-1:0]       out_armed;

    // Side that drives START pulses and reads the measurements.
    modport master (
        output in_start,
        output clr_stats,
        input  out_length,
        input  out_valid,
        input  out_sat,
        input  out_min,
        input  out_max,
        input  out_armed
    );

    // Measurer side.
    modport slave (
        input  in_start,
        input  clr_stats,
        output out_length,
        output out_valid,
        output out_sat,
        output out_min,
        output out_max,
        output out_armed
    );
endinterface

// File: rtl/multi_cycle_measurer.sv
// Multi-channel START period measurer. Each channel counts clk cycles between
// consecutive START samples, reports a prescaled saturating length with a
// one-cycle valid strobe, and keeps min/max/sticky-saturation statistics.
module multi_cycle_measurer #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int OUT_W = 8,
    parameter int SHIFT = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_cycle_measurer_if.slave bus
);
    localparam logic [OUT_W-1:0] ALL_ONES = {OUT_W{1'b1}};

    logic [N_CH-1:0][OUT_W-1:0] len_arr;
    logic [N_CH-1:0][OUT_W-1:0] min_arr;
    logic [N_CH-1:0][OUT_W-1:0] max_arr;
    logic [N_CH-1:0]            valid_arr;
    logic [N_CH-1:0]            sat_arr;
    logic [N_CH-1:0]            armed_arr;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [OUT_W-1:0] scaled;
            logic             start;
            logic             report;
            logic             scaled_full;
            logic             armed_reg;
            logic             valid_reg;
            logic             sat_reg;
            logic [OUT_W-1:0] len_reg;
            logic [OUT_W-1:0] min_reg;
            logic [OUT_W-1:0] max_reg;

            assign start       = bus.in_start[gi];
            assign scaled      = cnt_reg[SHIFT+OUT_W-1:SHIFT];
            assign scaled_full = (scaled == ALL_ONES);
            // A START only produces a report once the channel has been armed
            // by an earlier START; the very first one just opens the interval.
            assign report      = start && armed_reg;
            // Counter freezes once the reported field is all-ones so a very
            // long gap reads as saturated instead of wrapping to a small value.
            assign cnt_next    = start       ? CNT_W'(1) :
                                 scaled_full ? cnt_reg   :
                                               cnt_reg + CNT_W'(1);

            // Cycle counter: restarts at 1 on every START, runs even while disarmed.
            always_ff @(posedge clk) begin
                if (rst) cnt_reg <= '0;
                else     cnt_reg <= cnt_next;
            end

            // Armed flag: set by the first START after reset, cleared only by reset.
            always_ff @(posedge clk) begin
                if (rst)        armed_reg <= 1'b0;
                else if (start) armed_reg <= 1'b1;
            end

            // Length report and its one-cycle strobe; length holds between reports.
            always_ff @(posedge clk) begin
                if (rst) begin
                    len_reg   <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= report;
                    if (report) len_reg <= scaled;
                end
            end

            // Min/max/sticky saturation; a clear coinciding with a report seeds
            // the statistics from that report rather than discarding it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    min_reg <= ALL_ONES;
                    max_reg <= '0;
                    sat_reg <= 1'b0;
                end else if (bus.clr_stats) begin
                    if (report) begin
                        min_reg <= scaled;
                        max_reg <= scaled;
                        sat_reg <= scaled_full;
                    end else begin
                        min_reg <= ALL_ONES;
                        max_reg <= '0;
                        sat_reg <= 1'b0;
                    end
                end else if (report) begin
                    if (scaled < min_reg) min_reg <= scaled;
                    if (scaled > max_reg) max_reg <= scaled;
                    if (scaled_full)      sat_reg <= 1'b1;
                end
            end

            assign len_arr[gi]   = len_reg;
            assign min_arr[gi]   = min_reg;
            assign max_arr[gi]   = max_reg;
            assign valid_arr[gi] = valid_reg;
            assign sat_arr[gi]   = sat_reg;
            assign armed_arr[gi] = armed_reg;
        end
    endgenerate

    assign bus.out_length = len_arr;
    assign bus.out_min    = min_arr;
    assign bus.out_max    = max_arr;
    assign bus.out_valid  = valid_arr;
    assign bus.out_sat    = sat_arr;
    assign bus.out_armed  = armed_arr;
endmodule

// File: tb/tb_multi_cycle_measurer.sv
// Directed bench for multi_cycle_measurer: a SHIFT=0 instance for the main
// scenarios and a SHIFT=4 instance for prescale and simultaneous STARTs.
module tb_multi_cycle_measurer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_cycle_measurer_if #(.N_CH(4), .OUT_W(8)) bus ();
    multi_cycle_measurer_if #(.N_CH(4), .OUT_W(8)) bus2 ();

    multi_cycle_measurer #(.N_CH(4), .CNT_W(16), .OUT_W(8), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    multi_cycle_measurer #(.N_CH(4), .CNT_W(16), .OUT_W(8), .SHIFT(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    function automatic logic [7:0] f8(input logic [31:0] v, input int ch);
        return v[ch*8 +: 8];
    endfunction

    // Advance n edges; outputs are then stable 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int ch);
        bus.in_start[ch] = 1'b1;
        step(1);
        bus.in_start[ch] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        checks++;
        if (bus.out_length !== 32'h0 || bus.out_valid !== 4'h0 || bus.out_sat !== 4'h0 ||
            bus.out_min !== 32'hFFFF_FFFF || bus.out_max !== 32'h0 || bus.out_armed !== 4'h0) begin
            errors++;
            $display("FAIL reset_state len=%h valid=%h sat=%h min=%h max=%h armed=%h",
                     bus.out_length, bus.out_valid, bus.out_sat, bus.out_min, bus.out_max, bus.out_armed);
        end
        $display("test_reset: len=%h min=%h max=%h", bus.out_length, bus.out_min, bus.out_max);
    endtask

    task automatic test_first_interval;
        step(8);
        pulse(0);
        checks++;
        if (bus.out_valid[0] !== 1'b0 || bus.out_armed[0] !== 1'b1) begin
            errors++;
            $display("FAIL arm_ch0 valid=%b armed=%b required valid=0 armed=1",
                     bus.out_valid[0], bus.out_armed[0]);
        end
        step(9);
        pulse(0);
        checks++;
        if (bus.out_valid[0] !== 1'b1 || f8(bus.out_length, 0) !== 8'd10 ||
            f8(bus.out_min, 0) !== 8'd10 || f8(bus.out_max, 0) !== 8'd10) begin
            errors++;
            $display("FAIL len10_ch0 valid=%b len=%0d min=%0d max=%0d required 1/10/10/10",
                     bus.out_valid[0], f8(bus.out_length, 0), f8(bus.out_min, 0), f8(bus.out_max, 0));
        end
        step(1);
        checks++;
        if (bus.out_valid !== 4'h0 || f8(bus.out_length, 0) !== 8'd10) begin
            errors++;
            $display("FAIL strobe_width valid=%h len=%0d required valid=0 len=10",
                     bus.out_valid, f8(bus.out_length, 0));
        end
        $display("test_first_interval: ch0 len=%0d", f8(bus.out_length, 0));
    endtask

    task automatic test_intervals;
        int gaps[3] = '{5, 12, 7};
        pulse(1);
        for (int i = 0; i < 3; i++) begin
            step(gaps[i] - 1);
            pulse(1);
            checks++;
            if (bus.out_valid[1] !== 1'b1 || f8(bus.out_length, 1) !== 8'(gaps[i])) begin
                errors++;
                $display("FAIL interval_ch1[%0d] valid=%b len=%0d required len=%0d",
                         i, bus.out_valid[1], f8(bus.out_length, 1), gaps[i]);
            end
            $display("test_intervals: ch1 gap %0d len=%0d", gaps[i], f8(bus.out_length, 1));
        end
        checks++;
        if (f8(bus.out_min, 1) !== 8'd5 || f8(bus.out_max, 1) !== 8'd12) begin
            errors++;
            $display("FAIL minmax_ch1 min=%0d max=%0d required 5/12", f8(bus.out_min, 1), f8(bus.out_max, 1));
        end
        checks++;
        if (f8(bus.out_length, 0) !== 8'd10 || f8(bus.out_min, 0) !== 8'd10 ||
            f8(bus.out_length, 2) !== 8'd0 || bus.out_armed !== 4'b0011) begin
            errors++;
            $display("FAIL isolation len0=%0d min0=%0d len2=%0d armed=%b required 10/10/0/0011",
                     f8(bus.out_length, 0), f8(bus.out_min, 0), f8(bus.out_length, 2), bus.out_armed);
        end
    endtask

    task automatic test_saturation;
        pulse(2);
        step(399);
        pulse(2);
        checks++;
        if (f8(bus.out_length, 2) !== 8'd255 || bus.out_sat[2] !== 1'b1 || bus.out_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL sat_ch2 len=%0d sat=%b valid=%b required 255/1/1",
                     f8(bus.out_length, 2), bus.out_sat[2], bus.out_valid[2]);
        end
        step(2);
        pulse(2);
        checks++;
        if (f8(bus.out_length, 2) !== 8'd3 || bus.out_sat[2] !== 1'b1 ||
            f8(bus.out_min, 2) !== 8'd3 || f8(bus.out_max, 2) !== 8'd255) begin
            errors++;
            $display("FAIL after_sat_ch2 len=%0d sat=%b min=%0d max=%0d required 3/1/3/255",
                     f8(bus.out_length, 2), bus.out_sat[2], f8(bus.out_min, 2), f8(bus.out_max, 2));
        end
        $display("test_saturation: ch2 len=%0d sat=%b", f8(bus.out_length, 2), bus.out_sat[2]);
    endtask

    task automatic test_clr_stats;
        pulse(0);                       // ch0 counter was frozen: reports 255
        checks++;
        if (f8(bus.out_length, 0) !== 8'd255 || bus.out_sat[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_ch0 len=%0d sat=%b required 255/1", f8(bus.out_length, 0), bus.out_sat[0]);
        end
        step(8);
        bus.in_start[0] = 1'b1;
        bus.clr_stats   = 1'b1;
        step(1);
        bus.in_start[0] = 1'b0;
        bus.clr_stats   = 1'b0;
        checks++;
        if (f8(bus.out_length, 0) !== 8'd9 || f8(bus.out_min, 0) !== 8'd9 ||
            f8(bus.out_max, 0) !== 8'd9 || bus.out_sat !== 4'h0) begin
            errors++;
            $display("FAIL clr_with_report len=%0d min=%0d max=%0d sat=%h required 9/9/9/0",
                     f8(bus.out_length, 0), f8(bus.out_min, 0), f8(bus.out_max, 0), bus.out_sat);
        end
        checks++;
        if (f8(bus.out_min, 1) !== 8'hFF || f8(bus.out_max, 2) !== 8'd0 || f8(bus.out_length, 1) !== 8'd7) begin
            errors++;
            $display("FAIL clr_others min1=%h max2=%0d len1=%0d required FF/0/7",
                     f8(bus.out_min, 1), f8(bus.out_max, 2), f8(bus.out_length, 1));
        end
        bus.clr_stats = 1'b1;
        step(1);
        bus.clr_stats = 1'b0;
        checks++;
        if (f8(bus.out_min, 0) !== 8'hFF || f8(bus.out_max, 0) !== 8'd0 || f8(bus.out_length, 0) !== 8'd9) begin
            errors++;
            $display("FAIL clr_alone min=%h max=%0d len=%0d required FF/0/9",
                     f8(bus.out_min, 0), f8(bus.out_max, 0), f8(bus.out_length, 0));
        end
        $display("test_clr_stats: ch0 min=%h max=%h", f8(bus.out_min, 0), f8(bus.out_max, 0));
    endtask

    task automatic test_mid_reset;
        pulse(3);
        step(3);
        rst = 1'b1;
        step(1);
        checks++;
        if (bus.out_length !== 32'h0 || bus.out_valid !== 4'h0 || bus.out_sat !== 4'h0 ||
            bus.out_min !== 32'hFFFF_FFFF || bus.out_max !== 32'h0 || bus.out_armed !== 4'h0) begin
            errors++;
            $display("FAIL during_rst len=%h valid=%h sat=%h min=%h max=%h armed=%h",
                     bus.out_length, bus.out_valid, bus.out_sat, bus.out_min, bus.out_max, bus.out_armed);
        end
        rst = 1'b0;
        step(2);
        pulse(3);
        checks++;
        if (bus.out_valid[3] !== 1'b0 || bus.out_armed !== 4'b1000) begin
            errors++;
            $display("FAIL rearm_ch3 valid=%b armed=%b required 0/1000", bus.out_valid[3], bus.out_armed);
        end
        step(5);
        pulse(3);
        checks++;
        if (bus.out_valid[3] !== 1'b1 || f8(bus.out_length, 3) !== 8'd6) begin
            errors++;
            $display("FAIL post_rst_ch3 valid=%b len=%0d required 1/6", bus.out_valid[3], f8(bus.out_length, 3));
        end
        $display("test_mid_reset: ch3 len=%0d", f8(bus.out_length, 3));
    endtask

    task automatic test_back_to_back;
        pulse(1);                       // arm ch1 after the reset
        bus.in_start[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (bus.out_valid[1] !== 1'b1 || f8(bus.out_length, 1) !== 8'd1) begin
                errors++;
                $display("FAIL held_start[%0d] valid=%b len=%0d required 1/1",
                         i, bus.out_valid[1], f8(bus.out_length, 1));
            end
            $display("test_back_to_back: held cycle %0d len=%0d", i, f8(bus.out_length, 1));
        end
        bus.in_start[1] = 1'b0;
    endtask

    task automatic test_prescale;
        bus2.in_start[0] = 1'b1;
        step(1);
        bus2.in_start[0] = 1'b0;
        step(99);
        bus2.in_start[0] = 1'b1;
        step(1);
        bus2.in_start[0] = 1'b0;
        checks++;
        if (bus2.out_valid[0] !== 1'b1 || f8(bus2.out_length, 0) !== 8'd6) begin
            errors++;
            $display("FAIL prescale_len valid=%b len=%0d required 1/6", bus2.out_valid[0], f8(bus2.out_length, 0));
        end
        bus2.in_start = 4'hF;
        step(1);
        bus2.in_start = 4'h0;
        step(99);
        bus2.in_start = 4'hF;
        step(1);
        bus2.in_start = 4'h0;
        checks++;
        if (bus2.out_valid !== 4'hF || bus2.out_length !== 32'h0606_0606) begin
            errors++;
            $display("FAIL simultaneous valid=%h len=%h required F/06060606", bus2.out_valid, bus2.out_length);
        end
        $display("test_prescale: valid=%h len=%h", bus2.out_valid, bus2.out_length);
    endtask

    initial begin
        bus.in_start   = '0;
        bus.clr_stats  = 1'b0;
        bus2.in_start  = '0;
        bus2.clr_stats = 1'b0;
        test_reset();
        test_first_interval();
        test_intervals();
        test_saturation();
        test_clr_stats();
        test_mid_reset();
        test_back_to_back();
        test_prescale();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
